// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: reset vector, NOP and FSM encodings.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for the fetch unit; expire is raised on the last allowed wait cycle.
module fetch_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    logic [7:0] count_r;

    assign expire = enable && (count_r == 8'(LIMIT - 1));

    // Count cycles spent waiting; saturate at the expiry value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable && !expire) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read, registered outputs.
// Optional bus timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK_I,
    input  logic        Reset_I,
    input  logic [31:0] PC_I,
    input  logic        Start_I,
    input  logic        Ack_I,
    input  logic [31:0] Data_I,
    output logic [31:0] Addr_O,
    output logic        Req_O,
    output logic [31:0] IR_O,
    output logic        Valid_O,
    output logic        Busy_O,
    output logic        AddrErr_O,
    output logic        BusErr_O
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be in 2..255");
    end

    fetch_state_t state_r, state_s;
    logic [31:0]  addr_r, addr_s;
    logic [31:0]  ir_r, ir_s;
    logic         req_r, req_s;
    logic         valid_r, valid_s;
    logic         addr_err_r, addr_err_s;
    logic         bus_err_r, bus_err_s;
    logic         timeout_s;

`ifdef FETCH_TIMEOUT_EN
    fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_fetch_timer (
        .clk    (CLK_I),
        .rst    (Reset_I),
        .enable (state_r == ST_WAIT),
        .clear  (state_r != ST_WAIT),
        .expire (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic; Ack_I outranks timeout expiry.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        ir_s       = ir_r;
        req_s      = req_r;
        valid_s    = 1'b0;
        addr_err_s = 1'b0;
        bus_err_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start_I) begin
                    if (is_word_aligned(PC_I[1:0])) begin
                        addr_s  = PC_I;
                        req_s   = 1'b1;
                        state_s = ST_WAIT;
                    end else begin
                        addr_err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (Ack_I) begin
                    ir_s    = Data_I;
                    valid_s = 1'b1;
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end else if (timeout_s) begin
                    bus_err_s = 1'b1;
                    req_s     = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                req_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any request or acknowledge.
    always_ff @(posedge CLK_I) begin
        if (Reset_I) begin
            state_r    <= ST_IDLE;
            addr_r     <= RESET_VECTOR;
            ir_r       <= NOP_INSTR;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            addr_err_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            ir_r       <= ir_s;
            req_r      <= req_s;
            valid_r    <= valid_s;
            addr_err_r <= addr_err_s;
            bus_err_r  <= bus_err_s;
        end
    end

    assign Addr_O    = addr_r;
    assign Req_O     = req_r;
    assign IR_O      = ir_r;
    assign Valid_O   = valid_r;
    assign Busy_O    = (state_r == ST_WAIT);
    assign AddrErr_O = addr_err_r;
    assign BusErr_O  = bus_err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit; expected pulses are queued by stimulus and popped by a monitor.
module tb_fetch_unit;

    localparam int K_VALID   = 0;
    localparam int K_ADDRERR = 1;
    localparam int K_BUSERR  = 2;
`ifdef FETCH_TIMEOUT_EN
    localparam int ACK_DELAY = 2;
`else
    localparam int ACK_DELAY = 5;
`endif

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic        CLK_I = 1'b0;
    logic        Reset_I;
    logic [31:0] PC_I;
    logic        Start_I;
    logic        Ack_I;
    logic [31:0] Data_I;
    logic [31:0] Addr_O;
    logic        Req_O;
    logic [31:0] IR_O;
    logic        Valid_O;
    logic        Busy_O;
    logic        AddrErr_O;
    logic        BusErr_O;

    int   tests_run = 0;
    int   failed    = 0;
    int   valid_cnt = 0;
    logic prev_any  = 1'b0;
    exp_t exp_q[$];

    fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK_I     (CLK_I),
        .Reset_I   (Reset_I),
        .PC_I      (PC_I),
        .Start_I   (Start_I),
        .Ack_I     (Ack_I),
        .Data_I    (Data_I),
        .Addr_O    (Addr_O),
        .Req_O     (Req_O),
        .IR_O      (IR_O),
        .Valid_O   (Valid_O),
        .Busy_O    (Busy_O),
        .AddrErr_O (AddrErr_O),
        .BusErr_O  (BusErr_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic expect_event(input int kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pop the scoreboard whenever the DUT pulses an event output.
    always @(negedge CLK_I) begin
        logic any;
        int   kind_now;
        exp_t e;
        any = Valid_O || AddrErr_O || BusErr_O;
        if (any) begin
            kind_now = Valid_O ? K_VALID : (AddrErr_O ? K_ADDRERR : K_BUSERR);
            check("one_hot", 32'(int'(Valid_O) + int'(AddrErr_O) + int'(BusErr_O)), 32'd1);
            if (Valid_O) valid_cnt++;
            if (prev_any) begin
                tests_run++;
                failed++;
                $display("FAIL pulse_width: event pulse lasted more than one cycle at %0t", $time);
            end
            if (exp_q.size() == 0) begin
                tests_run++;
                failed++;
                $display("FAIL unexpected_event: kind %0d seen, none expected at %0t", kind_now, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(kind_now), 32'(e.kind));
                if (e.kind == K_VALID) check("ir_on_valid", IR_O, e.data);
            end
        end
        prev_any = any;
    end

    initial begin
        Reset_I = 1'b1; Start_I = 1'b0; Ack_I = 1'b0;
        PC_I = 32'h0; Data_I = 32'h0;
        step(); step();
        check("rst_addr", Addr_O, 32'hBFC00000);
        check("rst_req", {31'd0, Req_O}, 32'd0);
        check("rst_ir", IR_O, 32'h0);
        check("rst_busy", {31'd0, Busy_O}, 32'd0);
        Reset_I = 1'b0;

        // Minimum-latency fetch at the reset vector.
        Start_I = 1'b1; PC_I = 32'hBFC00000;
        expect_event(K_VALID, 32'h3C1DBFC0);
        step();
        Start_I = 1'b0;
        check("t1_req", {31'd0, Req_O}, 32'd1);
        check("t1_addr", Addr_O, 32'hBFC00000);
        check("t1_busy", {31'd0, Busy_O}, 32'd1);
        Ack_I = 1'b1; Data_I = 32'h3C1DBFC0;
        step();
        Ack_I = 1'b0;
        check("t1_valid", {31'd0, Valid_O}, 32'd1);
        check("t1_req_drop", {31'd0, Req_O}, 32'd0);
        step();

        // Delayed acknowledge: request and address held.
        Start_I = 1'b1; PC_I = 32'h00400004;
        expect_event(K_VALID, 32'h8C020000);
        step();
        Start_I = 1'b0;
        for (int i = 0; i < ACK_DELAY; i++) begin
            check("t2_req_hold", {31'd0, Req_O}, 32'd1);
            check("t2_addr_hold", Addr_O, 32'h00400004);
            step();
        end
        check("t2_req_last", {31'd0, Req_O}, 32'd1);
        Ack_I = 1'b1; Data_I = 32'h8C020000;
        step();
        Ack_I = 1'b0;
        check("t2_req_drop", {31'd0, Req_O}, 32'd0);
        check("t2_ir", IR_O, 32'h8C020000);
        step();

        // Misaligned PC.
        Start_I = 1'b1; PC_I = 32'h00400002;
        expect_event(K_ADDRERR, 32'h0);
        step();
        Start_I = 1'b0;
        check("t3_addrerr", {31'd0, AddrErr_O}, 32'd1);
        check("t3_req", {31'd0, Req_O}, 32'd0);
        check("t3_busy", {31'd0, Busy_O}, 32'd0);
        check("t3_ir", IR_O, 32'h8C020000);
        check("t3_addr", Addr_O, 32'h00400004);
        step();
        check("t3_addrerr_off", {31'd0, AddrErr_O}, 32'd0);

        // Reset in the second WAIT cycle, then a stale acknowledge.
        Start_I = 1'b1; PC_I = 32'h00400010;
        step();
        Start_I = 1'b0;
        step();
        Reset_I = 1'b1; Start_I = 1'b1; Ack_I = 1'b1; Data_I = 32'hDEADBEEF;
        step();
        Reset_I = 1'b0; Start_I = 1'b0;
        check("t4_req", {31'd0, Req_O}, 32'd0);
        check("t4_ir", IR_O, 32'h0);
        check("t4_addr", Addr_O, 32'hBFC00000);
        step();
        Ack_I = 1'b0;
        check("t4_no_valid", {31'd0, Valid_O}, 32'd0);
        check("t4_ir_after", IR_O, 32'h0);
        step();

        // Start held for 10 cycles: accepted every other cycle.
        for (int i = 0; i < 10; i++) begin
            Start_I = 1'b1;
            PC_I    = 32'h00400100 + 32'(4 * i);
            Ack_I   = (i % 2 == 1);
            Data_I  = 32'h10000000 + 32'(i);
            if (i % 2 == 1) begin
                check("t5_addr", Addr_O, 32'h00400100 + 32'(4 * (i - 1)));
                expect_event(K_VALID, 32'h10000000 + 32'(i));
            end
            step();
        end
        Start_I = 1'b0; Ack_I = 1'b0;
        step(); step();
        check("t5_ir_last", IR_O, 32'h10000009);

`ifdef FETCH_TIMEOUT_EN
        // Timeout with no acknowledge.
        Start_I = 1'b1; PC_I = 32'h00400200;
        expect_event(K_BUSERR, 32'h0);
        step();
        Start_I = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_req_hold", {31'd0, Req_O}, 32'd1);
            step();
        end
        check("t6_buserr", {31'd0, BusErr_O}, 32'd1);
        check("t6_req_drop", {31'd0, Req_O}, 32'd0);
        check("t6_busy", {31'd0, Busy_O}, 32'd0);
        check("t6_ir", IR_O, 32'h10000009);
        step();

        // Acknowledge in the expiry cycle completes normally.
        Start_I = 1'b1; PC_I = 32'h00400300;
        step();
        Start_I = 1'b0;
        step(); step(); step();
        Ack_I = 1'b1; Data_I = 32'hCAFEF00D;
        expect_event(K_VALID, 32'hCAFEF00D);
        step();
        Ack_I = 1'b0;
        check("t7_ir", IR_O, 32'hCAFEF00D);
        check("t7_buserr", {31'd0, BusErr_O}, 32'd0);
`else
        // No timeout: WAIT persists until acknowledged.
        Start_I = 1'b1; PC_I = 32'h00400300;
        step();
        Start_I = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("t6_busy", {31'd0, Busy_O}, 32'd1);
        check("t6_req", {31'd0, Req_O}, 32'd1);
        check("t6_buserr", {31'd0, BusErr_O}, 32'd0);
        Ack_I = 1'b1; Data_I = 32'hCAFEF00D;
        expect_event(K_VALID, 32'hCAFEF00D);
        step();
        Ack_I = 1'b0;
        check("t7_ir", IR_O, 32'hCAFEF00D);
`endif
        step(); step(); step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("valid_count", 32'(valid_cnt), 32'd8);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait cycles for Ack_I before bus error (range 2..255).
REQ-002 SHALL have CLK_I  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have Reset_I  input  1  reset, synchronous, active-high.
REQ-004 SHALL have PC_I  input  32  fetch address supplied by the program counter.
REQ-005 SHALL have Start_I  input  1  single-cycle fetch request from control.
REQ-006 SHALL have Ack_I  input  1  instruction-memory acknowledge, read data valid.
REQ-007 SHALL have Data_I  input  32  instruction-memory read data.
REQ-008 SHALL have Addr_O  output  32  registered instruction-memory address.
REQ-009 SHALL have Req_O  output  1  registered memory read request.
REQ-010 SHALL have IR_O  output  32  instruction register.
REQ-011 SHALL have Valid_O  output  1  one-cycle pulse: IR_O updated this cycle.
REQ-012 SHALL have Busy_O  output  1  high while a fetch is outstanding.
REQ-013 SHALL have AddrErr_O  output  1  one-cycle pulse: misaligned PC_I on Start_I.
REQ-014 SHALL have BusErr_O  output  1  one-cycle pulse: fetch timed out.

Function
REQ-015 SHALL implement FSM states IDLE and WAIT; Busy_O = (state==WAIT).
REQ-016 IDLE, Start_I=1, PC_I[1:0]==0: SHALL next cycle set Addr_O<=PC_I, Req_O<=1, state<=WAIT.
REQ-017 IDLE, Start_I=1, PC_I[1:0]!=0: SHALL pulse AddrErr_O next cycle, keep Req_O=0, stay IDLE, leave Addr_O/IR_O unchanged.
REQ-018 WAIT: SHALL hold Req_O=1 and Addr_O stable until Ack_I sampled high.
REQ-019 WAIT, Ack_I=1: SHALL next cycle set IR_O<=Data_I, pulse Valid_O, clear Req_O, return IDLE (one-cycle acknowledge-to-valid latency).
REQ-020 Start_I in WAIT SHALL be ignored (no queueing); Ack_I in IDLE SHALL be ignored.
REQ-021 Minimum fetch: Start_I cycle N, Req_O high N+1, Ack_I at N+1, Valid_O at N+2; back-to-back Start_I accepted at N+2.
REQ-022 Valid_O, AddrErr_O, BusErr_O SHALL be mutually exclusive and each at most one cycle wide.

Reset
REQ-023 Reset_I high at a rising edge SHALL force IDLE, Addr_O=32'hBFC00000, Req_O=0, IR_O=32'h00000000, Valid_O=AddrErr_O=BusErr_O=0, timeout count 0.
REQ-024 Reset_I mid-WAIT SHALL abandon the fetch: Req_O drops next edge, no Valid_O, a later Ack_I ignored.
REQ-025 Reset_I SHALL take priority over Start_I and Ack_I in the same cycle.

Configuration
REQ-026 Macro FETCH_TIMEOUT_EN defined: SHALL count WAIT cycles; with no Ack_I after TIMEOUT_CYCLES cycles of Req_O high, SHALL pulse BusErr_O, clear Req_O, keep IR_O, return IDLE; Ack_I in the expiry cycle SHALL win (normal completion).
REQ-027 Macro undefined: SHALL wait indefinitely in WAIT; BusErr_O tied 0; no counter logic.

Structure
REQ-028 Shared package/header SHALL hold reset vector 32'hBFC00000, NOP 32'h0, FSM state encodings.
REQ-029 Timeout counter SHALL be sub-module fetch_timer (enable/clear/expire), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-030 Reset, then Start_I with PC_I=32'hBFC00000 and immediate Ack_I, Data_I=32'h3C1DBFC0 -> Req_O at cycle 1, Valid_O and IR_O=32'h3C1DBFC0 at cycle 2.
REQ-031 Start_I with PC_I=32'h00400004, Ack_I delayed 5 cycles -> Req_O high 6 cycles, Addr_O stable 32'h00400004, one Valid_O.
REQ-032 Start_I with PC_I=32'h00400002 -> AddrErr_O one cycle, Req_O stays 0, IR_O unchanged.
REQ-033 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no Ack_I -> BusErr_O after 4 Req_O-high cycles, IR_O unchanged, Busy_O low next cycle.
REQ-034 Reset_I in 2nd WAIT cycle, Ack_I next cycle -> no Valid_O, IR_O=0, Addr_O=32'hBFC00000.
REQ-035 Start_I held high 10 cycles with Ack_I one cycle after each Req_O rise -> back-to-back fetches, one Valid_O per fetch, none dropped or duplicated.
